// File: rtl/port_stats_dt.sv
// port_stats_dt
//   Per-port buffer-occupancy tracker with a dynamic-threshold (DT) engine.
//   Each port keeps a saturating byte counter fed by enqueue, dequeue and
//   head-drop events. The registered total drives the DT threshold
//   T = (BUF_BYTES - total) scaled by 2^+/-ALPHA_SHIFT. T is compared per port
//   to produce the admission bitmap (bitmap_dt) and the head-drop eligibility
//   bitmap (bitmap). The block also keeps peak watermarks, sticky
//   underflow/overflow flags and a one-cycle readback port.
// Ports
//   clk, rst                  clock, async active-high reset
//   in/in_port/pkt_len_in     enqueue event
//   out/out_port/pkt_len_out  dequeue event
//   headdrop_out/_port/_len   head-drop event
//   bitmap_dt, bitmap         admission / head-drop bitmaps
//   total_occ                 registered total occupancy
//   rd_en, rd_port            readback request
//   rd_valid, rd_occ, rd_peak readback response (next cycle)
//   err_clr                   clears sticky error flags
//   err_underflow/overflow    sticky per-port error flags

// Per-port lane: net delta, saturation, peak tracking, sticky errors.
module port_stats_lane #(
  parameter int OCC_W = 16,
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_hit,
  input  logic [LEN_W-1:0] in_len,
  input  logic             out_hit,
  input  logic [LEN_W-1:0] out_len,
  input  logic             hd_hit,
  input  logic [LEN_W-1:0] hd_len,
  input  logic             rd_clr,
  input  logic             err_clr,
  output logic [OCC_W-1:0] occ,
  output logic [OCC_W-1:0] peak,
  output logic             err_uf,
  output logic             err_of
);
  localparam int SW = OCC_W + 2;
  localparam logic signed [SW-1:0] OCC_MAX = {2'b00, {OCC_W{1'b1}}};

  logic signed [SW-1:0] delta, occ_sum;
  logic                 uf, of;
  logic [OCC_W-1:0]     occ_d, occ_q, peak_d, peak_q;
  logic                 err_uf_d, err_uf_q, err_of_d, err_of_q;

  always_comb begin
    delta = '0;
    if (in_hit)  delta = delta + signed'(SW'(in_len));
    if (out_hit) delta = delta - signed'(SW'(out_len));
    if (hd_hit)  delta = delta - signed'(SW'(hd_len));
    occ_sum = signed'(SW'(occ_q)) + delta;
    uf = occ_sum[SW-1];
    of = occ_sum > OCC_MAX;
    if (uf)      occ_d = '0;
    else if (of) occ_d = '1;
    else         occ_d = occ_sum[OCC_W-1:0];
    // A read-clear restarts the watermark from the post-event occupancy.
    if (rd_clr)              peak_d = occ_d;
    else if (occ_d > peak_q) peak_d = occ_d;
    else                     peak_d = peak_q;
    // Set beats clear so an error in the clearing cycle is not lost.
    err_uf_d = uf | (err_uf_q & ~err_clr);
    err_of_d = of | (err_of_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q    <= '0;
      peak_q   <= '0;
      err_uf_q <= 1'b0;
      err_of_q <= 1'b0;
    end else begin
      occ_q    <= occ_d;
      peak_q   <= peak_d;
      err_uf_q <= err_uf_d;
      err_of_q <= err_of_d;
    end
  end

  assign occ    = occ_q;
  assign peak   = peak_q;
  assign err_uf = err_uf_q;
  assign err_of = err_of_q;
endmodule

module port_stats_dt #(
  parameter int NUM_PORTS   = 4,
  parameter int PORT_W      = 2,
  parameter int LEN_W       = 11,
  parameter int OCC_W       = 16,
  parameter int BUF_BYTES   = 32768,
  parameter int ALPHA_SHIFT = 0,
  parameter int ALPHA_DIR   = 0,
  parameter int PEAK_RC     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in,
  input  logic [PORT_W-1:0]    in_port,
  input  logic [LEN_W-1:0]     pkt_len_in,
  input  logic                 out,
  input  logic [PORT_W-1:0]    out_port,
  input  logic [LEN_W-1:0]     pkt_len_out,
  input  logic                 headdrop_out,
  input  logic [PORT_W-1:0]    headdrop_out_port,
  input  logic [LEN_W-1:0]     headdrop_pkt_len_out,
  output logic [NUM_PORTS-1:0] bitmap_dt,
  output logic [NUM_PORTS-1:0] bitmap,
  output logic [OCC_W-1:0]     total_occ,
  input  logic                 rd_en,
  input  logic [PORT_W-1:0]    rd_port,
  output logic                 rd_valid,
  output logic [OCC_W-1:0]     rd_occ,
  output logic [OCC_W-1:0]     rd_peak,
  input  logic                 err_clr,
  output logic [NUM_PORTS-1:0] err_underflow,
  output logic [NUM_PORTS-1:0] err_overflow
);
  localparam int SUM_W = OCC_W + PORT_W + 1;
  localparam int TW    = OCC_W + ALPHA_SHIFT + 1;
  localparam logic [OCC_W-1:0] BUF_L = OCC_W'(BUF_BYTES);

  logic [NUM_PORTS-1:0]            in_hit, out_hit, hd_hit, rd_hit, rd_clr;
  logic [NUM_PORTS-1:0][OCC_W-1:0] occ, peak, occ_dly_d, occ_dly_q;
  logic [SUM_W-1:0]                sum;
  logic [OCC_W-1:0]                total_d, total_q, room;
  logic [TW-1:0]                   thr;
  logic [NUM_PORTS-1:0]            bitmap_dt_d, bitmap_dt_q, bitmap_d, bitmap_q;
  logic                            rd_valid_d, rd_valid_q;
  logic [OCC_W-1:0]                rd_occ_d, rd_occ_q, rd_peak_d, rd_peak_q;

  // Port decode; indices >= NUM_PORTS match no lane and are dropped.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      in_hit[p]  = in           && (in_port           == PORT_W'(p));
      out_hit[p] = out          && (out_port          == PORT_W'(p));
      hd_hit[p]  = headdrop_out && (headdrop_out_port == PORT_W'(p));
      rd_hit[p]  = rd_en        && (rd_port           == PORT_W'(p));
    end
  end

  assign rd_clr = (PEAK_RC != 0) ? rd_hit : '0;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_lane
    port_stats_lane #(.OCC_W(OCC_W), .LEN_W(LEN_W)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .in_hit  (in_hit[g]),
      .in_len  (pkt_len_in),
      .out_hit (out_hit[g]),
      .out_len (pkt_len_out),
      .hd_hit  (hd_hit[g]),
      .hd_len  (headdrop_pkt_len_out),
      .rd_clr  (rd_clr[g]),
      .err_clr (err_clr),
      .occ     (occ[g]),
      .peak    (peak[g]),
      .err_uf  (err_underflow[g]),
      .err_of  (err_overflow[g])
    );
  end

  // Total stage. occ is delayed alongside it so the bitmap stage compares
  // each port against a threshold built from the same occupancy snapshot.
  always_comb begin
    sum = '0;
    for (int p = 0; p < NUM_PORTS; p++) sum = sum + SUM_W'(occ[p]);
    total_d   = (sum > SUM_W'({OCC_W{1'b1}})) ? '1 : sum[OCC_W-1:0];
    occ_dly_d = occ;
  end

  // Threshold / bitmap stage. thr is wide enough that a left shift never
  // truncates.
  always_comb begin
    room = (total_q >= BUF_L) ? '0 : (BUF_L - total_q);
    thr  = (ALPHA_DIR != 0) ? (TW'(room) >> ALPHA_SHIFT) : (TW'(room) << ALPHA_SHIFT);
    for (int p = 0; p < NUM_PORTS; p++) begin
      bitmap_dt_d[p] = TW'(occ_dly_q[p]) < thr;
      bitmap_d[p]    = TW'(occ_dly_q[p]) > thr;
    end
  end

  // Readback samples pre-event state; an out-of-range port returns zeros.
  always_comb begin
    rd_valid_d = rd_en;
    rd_occ_d   = rd_occ_q;
    rd_peak_d  = rd_peak_q;
    if (rd_en) begin
      rd_occ_d  = '0;
      rd_peak_d = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (rd_hit[p]) begin
          rd_occ_d  = occ[p];
          rd_peak_d = peak[p];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_dly_q   <= '0;
      total_q     <= '0;
      bitmap_dt_q <= '1;
      bitmap_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_occ_q    <= '0;
      rd_peak_q   <= '0;
    end else begin
      occ_dly_q   <= occ_dly_d;
      total_q     <= total_d;
      bitmap_dt_q <= bitmap_dt_d;
      bitmap_q    <= bitmap_d;
      rd_valid_q  <= rd_valid_d;
      rd_occ_q    <= rd_occ_d;
      rd_peak_q   <= rd_peak_d;
    end
  end

  assign total_occ = total_q;
  assign bitmap_dt = bitmap_dt_q;
  assign bitmap    = bitmap_q;
  assign rd_valid  = rd_valid_q;
  assign rd_occ    = rd_occ_q;
  assign rd_peak   = rd_peak_q;
endmodule

// File: tb/tb_port_stats_dt.sv
// Bench for port_stats_dt. Two instances share one stimulus stream:
//   d0: defaults (PORT_W=2, alpha=1)
//   d1: PORT_W=3, ALPHA_SHIFT=1, ALPHA_DIR=1 (alpha=1/2, illegal ports reachable)
// A per-instance history model predicts every output each cycle; directed
// scenarios add literal expectations.
module tb_port_stats_dt;
  logic clk = 1'b0;
  logic rst;
  logic in_v, out_v, hd_v, rd_en, err_clr;
  logic [2:0] in_port, out_port, hd_port, rd_port;
  logic [10:0] len_in, len_out, len_hd;

  logic [3:0]  a_bdt[2], a_bm[2], a_uf[2], a_of[2];
  logic [15:0] a_tot[2], a_rdo[2], a_rdp[2];
  logic        a_rdv[2];

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  port_stats_dt u_d0 (
    .clk(clk), .rst(rst),
    .in(in_v), .in_port(in_port[1:0]), .pkt_len_in(len_in),
    .out(out_v), .out_port(out_port[1:0]), .pkt_len_out(len_out),
    .headdrop_out(hd_v), .headdrop_out_port(hd_port[1:0]), .headdrop_pkt_len_out(len_hd),
    .bitmap_dt(a_bdt[0]), .bitmap(a_bm[0]), .total_occ(a_tot[0]),
    .rd_en(rd_en), .rd_port(rd_port[1:0]), .rd_valid(a_rdv[0]),
    .rd_occ(a_rdo[0]), .rd_peak(a_rdp[0]),
    .err_clr(err_clr), .err_underflow(a_uf[0]), .err_overflow(a_of[0])
  );

  port_stats_dt #(.PORT_W(3), .ALPHA_SHIFT(1), .ALPHA_DIR(1)) u_d1 (
    .clk(clk), .rst(rst),
    .in(in_v), .in_port(in_port), .pkt_len_in(len_in),
    .out(out_v), .out_port(out_port), .pkt_len_out(len_out),
    .headdrop_out(hd_v), .headdrop_out_port(hd_port), .headdrop_pkt_len_out(len_hd),
    .bitmap_dt(a_bdt[1]), .bitmap(a_bm[1]), .total_occ(a_tot[1]),
    .rd_en(rd_en), .rd_port(rd_port), .rd_valid(a_rdv[1]),
    .rd_occ(a_rdo[1]), .rd_peak(a_rdp[1]),
    .err_clr(err_clr), .err_underflow(a_uf[1]), .err_overflow(a_of[1])
  );

  // ---------------- behavioural model ----------------
  longint m_occ[2][4], m_peak[2][4], h1[2][4], h2[2][4];
  longint m_tot[2], m_rdo[2], m_rdp[2];
  logic   m_rdv[2];
  logic [3:0] m_bdt[2], m_bm[2], m_uf[2], m_of[2];
  longint nx, s1, s2, tv;
  int pr, pi, po, ph;

  function automatic int pmap(int d, logic [2:0] p);
    return (d == 0) ? int'(p[1:0]) : int'(p);
  endfunction

  // DT threshold for instance d given a total occupancy.
  function automatic longint thr(int d, longint tot);
    longint r;
    if (tot >= 32768) return 0;
    r = 32768 - tot;
    return (d == 0) ? r : (r >> 1);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 4; p++) begin
          m_occ[d][p] = 0; m_peak[d][p] = 0; h1[d][p] = 0; h2[d][p] = 0;
        end
        m_tot[d] = 0; m_rdo[d] = 0; m_rdp[d] = 0; m_rdv[d] = 1'b0;
        m_bdt[d] = 4'hf; m_bm[d] = 4'h0; m_uf[d] = 4'h0; m_of[d] = 4'h0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        for (int p = 0; p < 4; p++) begin
          h2[d][p] = h1[d][p];
          h1[d][p] = m_occ[d][p];
        end
        pr = pmap(d, rd_port); pi = pmap(d, in_port);
        po = pmap(d, out_port); ph = pmap(d, hd_port);
        m_rdv[d] = rd_en;
        if (rd_en) begin
          m_rdo[d] = (pr < 4) ? m_occ[d][pr] : 0;
          m_rdp[d] = (pr < 4) ? m_peak[d][pr] : 0;
        end
        if (err_clr) begin m_uf[d] = 4'h0; m_of[d] = 4'h0; end
        for (int p = 0; p < 4; p++) begin
          nx = m_occ[d][p];
          if (in_v  && pi == p) nx = nx + longint'(len_in);
          if (out_v && po == p) nx = nx - longint'(len_out);
          if (hd_v  && ph == p) nx = nx - longint'(len_hd);
          if (nx < 0) begin nx = 0; m_uf[d][p] = 1'b1; end
          else if (nx > 65535) begin nx = 65535; m_of[d][p] = 1'b1; end
          m_occ[d][p] = nx;
          if (rd_en && pr == p) m_peak[d][p] = nx;
          else if (nx > m_peak[d][p]) m_peak[d][p] = nx;
        end
        s1 = 0; s2 = 0;
        for (int p = 0; p < 4; p++) begin s1 = s1 + h1[d][p]; s2 = s2 + h2[d][p]; end
        m_tot[d] = (s1 > 65535) ? 65535 : s1;
        tv = thr(d, (s2 > 65535) ? 65535 : s2);
        for (int p = 0; p < 4; p++) begin
          m_bdt[d][p] = h2[d][p] < tv;
          m_bm[d][p]  = h2[d][p] > tv;
        end
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("total[%0d]", d), 64'(a_tot[d]), m_tot[d]);
        chk($sformatf("bitmap_dt[%0d]", d), 64'(a_bdt[d]), 64'(m_bdt[d]));
        chk($sformatf("bitmap[%0d]", d), 64'(a_bm[d]), 64'(m_bm[d]));
        chk($sformatf("err_uf[%0d]", d), 64'(a_uf[d]), 64'(m_uf[d]));
        chk($sformatf("err_of[%0d]", d), 64'(a_of[d]), 64'(m_of[d]));
        chk($sformatf("rd_valid[%0d]", d), 64'(a_rdv[d]), 64'(m_rdv[d]));
        if (m_rdv[d]) begin
          chk($sformatf("rd_occ[%0d]", d), 64'(a_rdo[d]), m_rdo[d]);
          chk($sformatf("rd_peak[%0d]", d), 64'(a_rdp[d]), m_rdp[d]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle();
    in_v = 1'b0; out_v = 1'b0; hd_v = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
    in_port = 3'd0; out_port = 3'd0; hd_port = 3'd0; rd_port = 3'd0;
    len_in = 11'd0; len_out = 11'd0; len_hd = 11'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic enq(input logic [2:0] p, input logic [10:0] l);
    in_v = 1'b1; in_port = p; len_in = l;
  endtask

  task automatic rnd(input int p_in, input int p_out);
    in_v    = $urandom_range(99) < p_in;
    in_port = 3'($urandom_range(7));
    len_in  = 11'($urandom_range(2047));
    out_v   = $urandom_range(99) < p_out;
    out_port = 3'($urandom_range(7));
    len_out = 11'($urandom_range(2047));
    hd_v    = $urandom_range(99) < 10;
    hd_port = 3'($urandom_range(7));
    len_hd  = 11'($urandom_range(2047));
    rd_en   = $urandom_range(3) == 0;
    rd_port = 3'($urandom_range(7));
    err_clr = $urandom_range(31) == 0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #1 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("reset_bitmap_dt", 64'(a_bdt[0]), 64'hf);
    chk("reset_total", 64'(a_tot[0]), 64'd0);

    // Single-port fill
    do_reset();
    enq(3'd0, 11'd1000);
    repeat (16) tick();
    idle(); repeat (3) tick();
    chk("fill16k_total", 64'(a_tot[0]), 64'd16000);
    chk("fill16k_bitmap_dt", 64'(a_bdt[0]), 64'b1111);
    chk("fill16k_bitmap", 64'(a_bm[0]), 64'b0000);
    enq(3'd0, 11'd500); tick();
    idle(); repeat (3) tick();
    chk("fill16k5_total", 64'(a_tot[0]), 64'd16500);
    chk("fill16k5_bitmap_dt", 64'(a_bdt[0]), 64'b1110);
    chk("fill16k5_bitmap", 64'(a_bm[0]), 64'b0001);

    // Simultaneous same-port events
    do_reset();
    enq(3'd2, 11'd40); tick();
    enq(3'd2, 11'd100);
    out_v = 1'b1; out_port = 3'd2; len_out = 11'd60;
    hd_v = 1'b1; hd_port = 3'd2; len_hd = 11'd30;
    tick();
    idle(); rd_en = 1'b1; rd_port = 3'd2; tick();
    idle();
    chk("same_rd_valid", 64'(a_rdv[0]), 64'd1);
    chk("same_rd_occ", 64'(a_rdo[0]), 64'd50);
    chk("same_rd_peak", 64'(a_rdp[0]), 64'd50);
    tick();
    chk("same_rd_valid_pulse", 64'(a_rdv[0]), 64'd0);

    // Underflow
    do_reset();
    enq(3'd1, 11'd10); tick();
    idle(); out_v = 1'b1; out_port = 3'd1; len_out = 11'd64; tick();
    idle();
    chk("uf_set", 64'(a_uf[0]), 64'b0010);
    tick();
    chk("uf_sticky", 64'(a_uf[0]), 64'b0010);
    rd_en = 1'b1; rd_port = 3'd1; tick(); idle();
    chk("uf_rd_occ", 64'(a_rdo[0]), 64'd0);
    err_clr = 1'b1; tick(); idle();
    chk("uf_cleared", 64'(a_uf[0]), 64'd0);

    // Alpha right-shift (instance d1)
    do_reset();
    enq(3'd3, 11'd2000); repeat (4) tick();
    idle(); repeat (3) tick();
    chk("alpha_8k_total", 64'(a_tot[1]), 64'd8000);
    chk("alpha_8k_bitmap_dt", 64'(a_bdt[1]), 64'b1111);
    chk("alpha_8k_bitmap", 64'(a_bm[1]), 64'b0000);
    enq(3'd3, 11'd2000); tick();
    enq(3'd3, 11'd1000); tick();
    idle(); repeat (3) tick();
    chk("alpha_11k_bitmap", 64'(a_bm[1]), 64'b1000);
    chk("alpha_11k_bitmap_dt", 64'(a_bdt[1]), 64'b0111);
    chk("alpha_11k_d0_bitmap_dt", 64'(a_bdt[0]), 64'b1111);

    // Peak read-clear and illegal readback port
    do_reset();
    enq(3'd0, 11'd1000); repeat (3) tick();
    idle(); out_v = 1'b1; out_port = 3'd0; len_out = 11'd1800; tick();
    idle(); rd_en = 1'b1; rd_port = 3'd0; tick();
    chk("peak_first", 64'(a_rdp[0]), 64'd3000);
    chk("peak_first_occ", 64'(a_rdo[0]), 64'd1200);
    tick();
    chk("peak_second", 64'(a_rdp[0]), 64'd1200);
    rd_port = 3'd5; tick(); idle();
    chk("illegal_rd_valid", 64'(a_rdv[1]), 64'd1);
    chk("illegal_rd_occ", 64'(a_rdo[1]), 64'd0);
    chk("illegal_rd_peak", 64'(a_rdp[1]), 64'd0);

    // Randomized phases: fill (overflow), drain (underflow), mixed
    do_reset();
    repeat (700) begin rnd(90, 10); tick(); end
    repeat (700) begin rnd(20, 80); tick(); end
    repeat (900) begin rnd(55, 45); tick(); end

    // Reset mid-operation
    idle();
    for (int p = 0; p < 4; p++) begin enq(3'(p), 11'd500); tick(); end
    idle(); rd_en = 1'b1; rd_port = 3'd0; tick();
    idle(); tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_total", 64'(a_tot[0]), 64'd0);
    chk("midrst_bitmap_dt", 64'(a_bdt[0]), 64'hf);
    chk("midrst_bitmap", 64'(a_bm[0]), 64'd0);
    chk("midrst_rd_valid", 64'(a_rdv[0]), 64'd0);
    chk("midrst_rd_occ", 64'(a_rdo[0]), 64'd0);
    chk("midrst_rd_peak", 64'(a_rdp[0]), 64'd0);
    chk("midrst_err", 64'({a_uf[0], a_of[0], a_uf[1], a_of[1]}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    enq(3'd0, 11'd64); tick();
    idle(); rd_en = 1'b1; rd_port = 3'd0; tick();
    idle();
    chk("post_rst_occ0", 64'(a_rdo[0]), 64'd64);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
